// File: rtl/uart_16bit_assembler.sv
//==============================================================================
// Module   : uart_16bit_assembler
// Purpose  : Pairs bytes from a FWFT UART receive FIFO into 16-bit words
//            {high, low}.  Optional half-word timeout: UART_ASM_TIMEOUT_EN.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module uart_16bit_assembler #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_empty,
    input  logic [7:0]  read_data,
    output logic        read_uart,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  word_cnt
);

    typedef enum logic [0:0] {
        WAIT_LO = 1'b0,
        WAIT_HI = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_low;
    logic [15:0] r_data_out;
    logic        r_data_valid;
    logic [7:0]  r_word_cnt;

    // The FIFO is never back-pressured: any available byte is consumed.
    assign read_uart  = ~rx_empty;
    assign busy       = (r_state == WAIT_HI);
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign word_cnt   = r_word_cnt;

`ifdef UART_ASM_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_to_cnt;
    logic               r_timeout_err;

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= WAIT_LO;
            r_low        <= 8'h00;
            r_data_out   <= 16'h0000;
            r_data_valid <= 1'b0;
            r_word_cnt   <= 8'h00;
`ifdef UART_ASM_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_data_valid <= 1'b0;
`ifdef UART_ASM_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                WAIT_LO: begin
                    if (!rx_empty) begin
                        r_low   <= read_data;
                        r_state <= WAIT_HI;
`ifdef UART_ASM_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                WAIT_HI: begin
                    // An arriving byte takes priority over an expiring timeout.
                    if (!rx_empty) begin
                        r_data_out   <= {read_data, r_low};
                        r_data_valid <= 1'b1;
                        r_word_cnt   <= r_word_cnt + 8'd1;
                        r_state      <= WAIT_LO;
                    end
`ifdef UART_ASM_TIMEOUT_EN
                    else if (r_to_cnt == c_CNT_LAST) begin
                        r_state       <= WAIT_LO;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= WAIT_LO;
            endcase
        end
    end

endmodule

`default_nettype wire
